// File: rtl/mult_hilo_controller.sv
// Sequential 32x32 shift-add multiplier owning the HI/LO registers, with a pipeline stall request.
// Optional early termination on an exhausted multiplier: define MULT_EARLY_TERM_EN.
module mult_hilo_controller (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_mult,
    input  logic        mult_sign,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        hilo_read,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        mult_busy,
    output logic        mult_done,
    output logic        stall
);

    localparam int unsigned DW = 32;
    localparam int unsigned PW = 64;
    localparam int unsigned CW = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   mcand_q, mcand_d;
    logic [DW-1:0]   mplier_q, mplier_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sign_q, sign_d;
    logic [DW-1:0]   hi_d, lo_d;
    logic [DW:0]     sum_c;
    logic [PW-1:0]   prod_c;
    logic            last_c;

    // Upper-half add with carry out; the carry becomes bit 63 after the shift.
    assign sum_c = {1'b0, acc_q[PW-1:DW]} + {1'b0, (mplier_q[0] ? mcand_q : '0)};

`ifdef MULT_EARLY_TERM_EN
    // Leave BUSY once no set multiplier bits remain; realign the partial product in DONE.
    assign last_c = (cnt_q == CW'(DW - 1)) || (mplier_q[DW-1:1] == '0);
    assign prod_c = acc_q >> (CW'(DW) - cnt_q);
`else
    assign last_c = (cnt_q == CW'(DW - 1));
    assign prod_c = acc_q;
`endif

    // A pipeline request arriving while the multiplier is occupied is held, not dropped.
    assign stall = (hilo_read | start_mult) & (state_q != IDLE);

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        hi_d     = hi;
        lo_d     = lo;
        case (state_q)
            IDLE: begin
                if (start_mult) begin
                    mcand_d  = (mult_sign && op_a[DW-1]) ? (~op_a + DW'(1)) : op_a;
                    mplier_d = (mult_sign && op_b[DW-1]) ? (~op_b + DW'(1)) : op_b;
                    sign_d   = mult_sign & (op_a[DW-1] ^ op_b[DW-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                acc_d    = {sum_c, acc_q[DW-1:1]};
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (last_c) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                {hi_d, lo_d} = sign_q ? (~prod_c + PW'(1)) : prod_c;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            mult_busy <= 1'b0;
            mult_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            hi        <= hi_d;
            lo        <= lo_d;
            mult_busy <= (state_d != IDLE);
            mult_done <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_mult_hilo_controller.sv
// Scoreboard bench for mult_hilo_controller: driver pushes expected transactions, negedge monitor checks.
module tb_mult_hilo_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_mult;
    logic        mult_sign;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        hilo_read;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        mult_busy;
    logic        mult_done;
    logic        stall;

    mult_hilo_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_mult (start_mult),
        .mult_sign  (mult_sign),
        .op_a       (op_a),
        .op_b       (op_b),
        .hilo_read  (hilo_read),
        .hi         (hi),
        .lo         (lo),
        .mult_busy  (mult_busy),
        .mult_done  (mult_done),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] prod;
        int          acc;
        int          lat;
    } txn_t;

    txn_t        sb[$];
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    int          last_acc = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    bit          exp_busy;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Full-width arithmetic reference for the 64-bit product.
    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sbv;
        if (s) begin
            sa  = longint'($signed(a));
            sbv = longint'($signed(b));
            return 64'(sa * sbv);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Edges from accept to HI/LO written: accept + BUSY cycles + DONE.
    function automatic int ref_lat(input logic [31:0] b, input logic s);
`ifdef MULT_EARLY_TERM_EN
        logic [31:0] m;
        int nb;
        m  = (s && b[31]) ? -b : b;
        nb = 0;
        for (int i = 0; i < 32; i++) if (m[i]) nb = i + 1;
        return ((nb == 0) ? 1 : nb) + 2;
`else
        return 34;
`endif
    endfunction

    // State after posedge number cyc is non-IDLE for the in-flight transaction.
    function automatic bit model_busy();
        if (sb.size() == 0) return 1'b0;
        return (cyc >= sb[0].acc) && (cyc < sb[0].acc + sb[0].lat - 1);
    endfunction

    // Monitor: every negedge out of reset compares flags and HI/LO against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_busy = model_busy();
            chk("mult_busy", 64'(mult_busy), 64'(exp_busy));
            chk("stall", 64'(stall), 64'((hilo_read | start_mult) & exp_busy));
            chk("mult_done", 64'(mult_done),
                64'((sb.size() > 0) && (cyc == sb[0].acc + sb[0].lat - 2)));
            if (sb.size() > 0 && cyc == sb[0].acc + sb[0].lat - 1) begin
                {m_hi, m_lo} = sb[0].prod;
                void'(sb.pop_front());
            end
            chk("hi", 64'(hi), 64'(m_hi));
            chk("lo", 64'(lo), 64'(m_lo));
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk("drain_timeout", 64'(sb.size()), 64'(0));
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [63:0] p, input bit hold);
        txn_t t;
        int   n = 0;
        @(negedge clk);
        #1;
        op_a = a; op_b = b; mult_sign = s; start_mult = 1'b1;
        while (model_busy() && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("accept_timeout", 64'(n >= 200), 64'(0));
        t.prod = p;
        t.acc  = cyc + 1;
        t.lat  = ref_lat(b, s);
        sb.push_back(t);
        last_acc = t.acc;
        @(negedge clk);
        #1;
        start_mult = 1'b0;
        op_a = $urandom; op_b = $urandom; mult_sign = 1'($urandom_range(0, 1));
        if (hold) begin
            hilo_read = 1'b1;
            wait_idle();
            repeat (2) @(negedge clk);
            #1;
            hilo_read = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        rst_n = 1'b0; start_mult = 1'b0; mult_sign = 1'b0;
        op_a = '0; op_b = '0; hilo_read = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        chk("rst_busy", 64'(mult_busy), 64'(0));
        chk("rst_done", 64'(mult_done), 64'(0));
        chk("rst_stall", 64'(stall), 64'(0));
        rst_n = 1'b1;

        issue(32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F, 1'b0);
        wait_idle();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b0);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, 1'b0);
        issue(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 1'b0);
        issue(32'hFFFF_FFFD, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
        // HI/LO read held across a whole multiply; then back-to-back issues stall the second start.
        issue(32'd1000, 32'd999, 1'b0, 64'd999000, 1'b1);
        issue(32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000, 1'b0);
        issue(32'hFFFF_FFF0, 32'd16, 1'b1, 64'hFFFF_FFFF_FFFF_FF00, 1'b0);
        wait_idle();

        // Reset in the middle of a multiply discards it and clears HI/LO.
        issue(32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 64'h0, 1'b0);
        while (cyc < last_acc + 10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        m_hi = '0; m_lo = '0;
        #1;
        chk("mid_rst_hi", 64'(hi), 64'(0));
        chk("mid_rst_lo", 64'(lo), 64'(0));
        chk("mid_rst_busy", 64'(mult_busy), 64'(0));
        chk("mid_rst_done", 64'(mult_done), 64'(0));
        chk("mid_rst_stall", 64'(stall), 64'(0));
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        issue(32'd2, 32'd2, 1'b0, 64'd4, 1'b0);
        issue(32'h1234_5678, 32'd1, 1'b0, 64'h0000_0000_1234_5678, 1'b0);
        issue(32'hDEAD_BEEF, 32'd0, 1'b1, 64'h0, 1'b0);
        wait_idle();

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'($urandom_range(0, 255));
                1:       rb = 32'h8000_0000;
                default: rb = $urandom;
            endcase
            rs = 1'($urandom_range(0, 1));
            hilo_read = 1'($urandom_range(0, 1));
            issue(ra, rb, rs, ref_prod(ra, rb, rs), (i % 6) == 5);
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
